// File: rtl/tdm_demux_1_4.sv
// 1:4 TDM demultiplexer: collects four consecutive valid samples (channel 0 marked
// by frame_sync) and publishes them as one atomic frame on y0..y3.
module tdm_demux_1_4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic             frame_valid,
    output logic [1:0]       ch_idx,
    output logic             sync_err
);

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [1:0]       ch_q;
    logic [WIDTH-1:0] shd0_q, shd1_q, shd2_q;
    logic [WIDTH-1:0] y0_q, y1_q, y2_q, y3_q;
    logic             fv_q, err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            ch_q    <= 2'd0;
            shd0_q  <= '0;
            shd1_q  <= '0;
            shd2_q  <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            y3_q    <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            fv_q  <= 1'b0;
            err_q <= 1'b0;
            if (din_valid) begin
                if (frame_sync) begin
                    // A sync mid-frame abandons the partial frame but still realigns on this sample.
                    if (state_q == RUN && ch_q != 2'd0)
                        err_q <= 1'b1;
                    shd0_q  <= din;
                    ch_q    <= 2'd1;
                    state_q <= RUN;
                end else if (state_q == RUN) begin
                    case (ch_q)
                        2'd0: begin
                            err_q   <= 1'b1;
                            state_q <= HUNT;
                        end
                        2'd1: begin
                            shd1_q <= din;
                            ch_q   <= 2'd2;
                        end
                        2'd2: begin
                            shd2_q <= din;
                            ch_q   <= 2'd3;
                        end
                        default: begin
                            // Channel 3 goes straight to y3 so the whole frame lands on one edge.
                            y0_q <= shd0_q;
                            y1_q <= shd1_q;
                            y2_q <= shd2_q;
                            y3_q <= din;
                            fv_q <= 1'b1;
                            ch_q <= 2'd0;
                        end
                    endcase
                end
            end
        end
    end

    assign y0          = y0_q;
    assign y1          = y1_q;
    assign y2          = y2_q;
    assign y3          = y3_q;
    assign frame_valid = fv_q;
    assign sync_err    = err_q;
    assign ch_idx      = ch_q;

endmodule

// File: tb/tb_tdm_demux_1_4.sv
// Self-checking bench for tdm_demux_1_4: directed scenarios plus random traffic
// compared against a queue-based frame model.
module tb_tdm_demux_1_4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       frame_sync = 1'b0;
    logic [7:0] y0, y1, y2, y3;
    logic       frame_valid, sync_err;
    logic [1:0] ch_idx;

    int checks = 0;
    int failures = 0;

    // Reference model: alignment flag, samples gathered for the current frame, published frame.
    bit         m_aligned;
    logic [7:0] m_part[$];
    logic [7:0] m_y[4];
    bit         m_fv, m_err;

    logic [36:0] got, exp;

    tdm_demux_1_4 #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_sync(frame_sync), .y0(y0), .y1(y1), .y2(y2), .y3(y3),
        .frame_valid(frame_valid), .ch_idx(ch_idx), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] m_ch();
        return m_aligned ? 2'(m_part.size()) : 2'd0;
    endfunction

    function automatic logic [36:0] m_vec();
        return {m_y[0], m_y[1], m_y[2], m_y[3], m_fv, m_err, m_ch()};
    endfunction

    function automatic logic [36:0] dut_vec();
        return {y0, y1, y2, y3, frame_valid, sync_err, ch_idx};
    endfunction

    task automatic model_reset();
        m_aligned = 0;
        m_part.delete();
        for (int i = 0; i < 4; i++) m_y[i] = 8'h00;
        m_fv = 0;
        m_err = 0;
    endtask

    task automatic model_step(input bit v, input bit s, input logic [7:0] d);
        m_fv = 0;
        m_err = 0;
        if (v) begin
            if (s) begin
                if (m_aligned && m_part.size() != 0) m_err = 1;
                m_part.delete();
                m_part.push_back(d);
                m_aligned = 1;
            end else if (m_aligned) begin
                if (m_part.size() == 0) begin
                    m_err = 1;
                    m_aligned = 0;
                end else begin
                    m_part.push_back(d);
                    if (m_part.size() == 4) begin
                        for (int i = 0; i < 4; i++) m_y[i] = m_part[i];
                        m_part.delete();
                        m_fv = 1;
                    end
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic cyc(input bit v, input bit s, input logic [7:0] d);
        @(negedge clk);
        din = d;
        din_valid = v;
        frame_sync = s;
        @(posedge clk);
        #1;
        model_step(v, s, d);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        got = dut_vec();
        if (got !== 37'd0) begin
            failures++;
            $display("FAIL reset_state got=%h want=0", got);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_frame();
        logic [7:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [1:0] want_ch[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        for (int i = 0; i < 4; i++) begin
            cyc(1, i == 0, d[i]);
            checks++;
            if (ch_idx !== want_ch[i]) begin
                failures++;
                $display("FAIL basic_ch_idx[%0d] got=%0d want=%0d", i, ch_idx, want_ch[i]);
            end
        end
        checks++;
        if ({y0, y1, y2, y3, frame_valid} !== {32'h11223344, 1'b1}) begin
            failures++;
            $display("FAIL basic_frame got=%h%h%h%h fv=%b want=11223344 fv=1", y0, y1, y2, y3, frame_valid);
        end
        cyc(0, 0, 8'h00);
        checks++;
        if ({y0, y1, y2, y3, frame_valid} !== {32'h11223344, 1'b0}) begin
            failures++;
            $display("FAIL basic_pulse_end got=%h%h%h%h fv=%b want=11223344 fv=0", y0, y1, y2, y3, frame_valid);
        end
    endtask

    task automatic test_gaps();
        logic [7:0] d[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        int fv_count = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1, i == 0, d[i]);
            fv_count += int'(frame_valid);
            for (int g = 0; g < int'($urandom_range(3, 1)); g++) begin
                cyc(0, $urandom_range(1, 0) == 1, 8'($urandom));
                fv_count += int'(frame_valid);
                checks++;
                got = dut_vec(); exp = m_vec();
                if (got !== exp) begin
                    failures++;
                    $display("FAIL gap_hold got=%h want=%h", got, exp);
                end
            end
        end
        checks++;
        if ({y0, y1, y2, y3} !== 32'h11223344 || fv_count != 1) begin
            failures++;
            $display("FAIL gap_frame got=%h%h%h%h pulses=%0d want=11223344 pulses=1", y0, y1, y2, y3, fv_count);
        end
    endtask

    task automatic test_hunt_discard();
        logic [7:0] d[6] = '{8'hAA, 8'hBB, 8'h01, 8'h02, 8'h03, 8'h04};
        bit         s[6] = '{0, 0, 1, 0, 0, 0};
        // Missing sync from RUN drops back to HUNT so the table starts unaligned.
        cyc(1, 0, 8'hEE);
        for (int i = 0; i < 6; i++) begin
            cyc(1, s[i], d[i]);
            checks++;
            got = dut_vec(); exp = m_vec();
            if (got !== exp || (i < 5 && sync_err)) begin
                failures++;
                $display("FAIL hunt_step[%0d] got=%h want=%h", i, got, exp);
            end
        end
        checks++;
        if ({y0, y1, y2, y3} !== 32'h01020304) begin
            failures++;
            $display("FAIL hunt_frame got=%h%h%h%h want=01020304", y0, y1, y2, y3);
        end
    endtask

    task automatic test_early_sync();
        logic [7:0] d[6] = '{8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA};
        bit         s[6] = '{1, 0, 1, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            cyc(1, s[i], d[i]);
            checks++;
            if (sync_err !== (i == 2) || (i < 5 && {y0, y1, y2, y3} !== 32'h01020304)) begin
                failures++;
                $display("FAIL early_sync[%0d] got y=%h%h%h%h err=%b", i, y0, y1, y2, y3, sync_err);
            end
        end
        checks++;
        if ({y0, y1, y2, y3, frame_valid} !== {32'h778899AA, 1'b1}) begin
            failures++;
            $display("FAIL early_frame got=%h%h%h%h fv=%b want=778899AA fv=1", y0, y1, y2, y3, frame_valid);
        end
    endtask

    task automatic test_missing_sync();
        cyc(1, 0, 8'h12);
        checks++;
        if ({sync_err, ch_idx, frame_valid} !== 4'b1000) begin
            failures++;
            $display("FAIL missing_sync got err=%b ch=%0d fv=%b want err=1 ch=0 fv=0", sync_err, ch_idx, frame_valid);
        end
        cyc(1, 0, 8'h34);
        checks++;
        if ({sync_err, ch_idx, frame_valid, y0, y1, y2, y3} !== {4'b0000, 32'h778899AA}) begin
            failures++;
            $display("FAIL hunt_ignore got err=%b ch=%0d fv=%b y=%h%h%h%h", sync_err, ch_idx, frame_valid, y0, y1, y2, y3);
        end
    endtask

    task automatic test_async_reset();
        cyc(1, 1, 8'h01);
        cyc(1, 0, 8'h02);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        got = dut_vec();
        if (got !== 37'd0) begin
            failures++;
            $display("FAIL async_reset got=%h want=0", got);
        end
        #1 rst_n = 1'b1;
        cyc(1, 0, 8'h03);
        cyc(1, 0, 8'h04);
        checks++;
        got = dut_vec(); exp = m_vec();
        if (got !== exp || frame_valid || sync_err) begin
            failures++;
            $display("FAIL after_reset got=%h want=%h", got, exp);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bit v = ($urandom_range(3, 0) != 0);
            bit s = ($urandom_range(5, 0) == 0);
            cyc(v, s, 8'($urandom));
            checks++;
            got = dut_vec(); exp = m_vec();
            if (got !== exp || (frame_valid && sync_err)) begin
                failures++;
                $display("FAIL random[%0d] got=%h want=%h", n, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_gaps();
        test_hunt_discard();
        test_early_sync();
        test_missing_sync();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
